rle_encoder_param: RTL
======================

// Module: rle_encoder_param
// PURPOSE
//  Parametrised run-length encoder. Reads a symbol stream from DPSRAM port A, emits {count,symbol}
//  pairs packed into DATA_W words back into the same SRAM at rle_addr. Successor of the fixed
//  8-bit/32-bit encoder; adds generic widths, count saturation, final-word flush and zero-size handling.
// PARAMETERS
//  DATA_W   32  SRAM word width (bits); must be a multiple of SYM_W and PAIR_W
//  ADDR_W   16  SRAM byte-address width
//  SYM_W     8  symbol width (bits), multiple of 8
//  CNT_W     8  run-count field width; max run per pair = 2**CNT_W-1
// PORTS
//  clk             in   1       clock; also drives port_A_clk
//  reset           in   1       asynchronous, active-high reset
//  start           in   1       1-cycle pulse, accepted only in IDLE
//  message_addr    in   32      byte address of input (low ADDR_W bits used, word aligned)
//  message_size    in   32      input length in symbols
//  rle_addr        in   32      byte address of output (word aligned)
//  rle_size        out  32      bytes written so far; final value valid when done=1
//  done            out  1       high from completion until next accepted start
//  port_A_clk      out  1       = clk
//  port_A_addr     out  ADDR_W  SRAM byte address
//  port_A_we       out  1       1=write, 0=read
//  port_A_data_in  out  DATA_W  write data to SRAM
//  port_A_data_out in   DATA_W  read data from SRAM, valid 1 cycle after address
// BEHAVIOUR
//  Reset (async): state=IDLE, done=0, rle_size=0, port_A_we=0, port_A_addr=0, port_A_data_in=0, internals 0.
//  Symbol order: symbol k of a word at bits [k*SYM_W +: SYM_W] (little-endian, k=0 first).
//  Pair = {cnt[CNT_W-1:0], sym[SYM_W-1:0]}, PAIR_W=SYM_W+CNT_W; pair j of an output word at [j*PAIR_W +: PAIR_W].
//  FSM: IDLE -start-> RD_REQ (addr=msg ptr, we=0) -> RD_WAIT (capture word) -> SCAN (one symbol/cycle)
//   SCAN: sym==cur && cnt<MAX -> cnt++; else emit pair {cnt,cur}, cur=sym, cnt=1.
//   Emit fills pack buffer; buffer full -> WR (we=1 one cycle, addr=out ptr, out ptr+=DATA_W/8,
//   rle_size+=DATA_W/8) -> back to SCAN. Word exhausted and symbols remain -> RD_REQ with msg ptr+=DATA_W/8.
//   Last symbol consumed -> emit final run -> FLUSH: partial buffer written zero-padded,
//   rle_size += (pairs_in_buffer*PAIR_W/8) (not padded bytes) -> DONE (done=1) -> IDLE waiting.
//  First symbol of message: cur=sym, cnt=1, no emit.
//  Saturation: run longer than MAX splits into {MAX,sym},{rest,sym}; no zero-count pair ever written.
//  message_size==0: start -> done=1 next cycle, rle_size=0, no SRAM writes.
//  Last input word partially used: symbols beyond message_size ignored.
//  start while busy (not IDLE/DONE) ignored; start in DONE clears done, rle_size, restarts.
//  Emit and buffer-full in same cycle as last symbol: WR then FLUSH (FLUSH skips write if buffer empty).
//  Pointers wrap modulo 2**ADDR_W silently.
//  Reset mid-run: immediate abort to IDLE, we=0 same edge; partial output left in SRAM.
//  port_A_we high only in WR/FLUSH-write cycles; never concurrent with a read.
// CONFIGURATION
//  RLE_STATS_EN: defined -> adds outputs run_count[31:0] (pairs emitted) and max_run[CNT_W-1:0]
//   (longest pair count this job), cleared on start/reset. Undefined -> ports and logic absent;
//   core behaviour identical.
// STRUCTURE
//  Package rle_pkg: state enum (IDLE,RD_REQ,RD_WAIT,SCAN,WR,FLUSH,DONE), localparams PAIR_W,
//   SYMS_PER_WORD, PAIRS_PER_WORD, CNT_MAX, byte-step constant.
//  Sub-module rle_pair_packer: accepts pair+valid, shifts into DATA_W buffer, raises full,
//   reports fill count, supports flush/clear. FSM, pointers, run tracker in top.
// TESTING
//  1. size=8, words 0x41414141,0x42424141 -> words 0x0242_0641 at rle_addr, rle_size=4, done=1.
//  2. size=300 all 0x55 -> pairs {FF,55},{2D,55}: word 0x2D55_FF55, rle_size=4.
//  3. size=0 -> done next cycle, rle_size=0, port_A_we never asserted.
//  4. size=5, 0x04030201,0x00000005 -> 5 pairs over 3 words, last padded 0, rle_size=10.
//  5. assert reset in SCAN -> outputs at reset values same cycle; new start completes correctly.
//  6. start pulsed during SCAN -> ignored, result identical to case 1; RLE_STATS_EN build: run_count=2,max_run=6.

Source files
------------

// File: rtl/rle_pkg.sv
// rle_pkg: shared state encoding and width helpers for the run-length encoder.
// The localparams describe the default 32/8/8 configuration; the functions
// derive the same quantities for any legal parameter set.
package rle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_SCAN,
    ST_WR,
    ST_FLUSH,
    ST_DONE
  } rle_state_e;

  function automatic int pair_width(input int sym_w, input int cnt_w);
    return sym_w + cnt_w;
  endfunction

  function automatic int syms_per_word(input int data_w, input int sym_w);
    return data_w / sym_w;
  endfunction

  function automatic int pairs_per_word(input int data_w, input int pair_w);
    return data_w / pair_w;
  endfunction

  function automatic int byte_step(input int data_w);
    return data_w / 8;
  endfunction

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_SYM_W      = 8;
  localparam int DEF_CNT_W      = 8;
  localparam int PAIR_W         = pair_width(DEF_SYM_W, DEF_CNT_W);
  localparam int SYMS_PER_WORD  = syms_per_word(DEF_DATA_W, DEF_SYM_W);
  localparam int PAIRS_PER_WORD = pairs_per_word(DEF_DATA_W, PAIR_W);
  localparam int CNT_MAX        = (2 ** DEF_CNT_W) - 1;
  localparam int BYTE_STEP      = byte_step(DEF_DATA_W);

endpackage

// File: rtl/rle_pair_packer.sv
// rle_pair_packer: collects {count,symbol} pairs into one output word.
// Pair j lands at bits [j*PAIR_W +: PAIR_W]; unused slots stay zero so a
// partially filled word is already zero-padded. The next-state buffer and
// fill are exported so the owner can register them in the same cycle a pair
// completes the word.
module rle_pair_packer #(
  parameter int DATA_W = 32,
  parameter int PAIR_W = 16,
  parameter int FILL_W = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [PAIR_W-1:0] pair_i,
  output logic [DATA_W-1:0] buf_next_o,
  output logic [FILL_W-1:0] fill_next_o,
  output logic              full_next_o
);

  localparam int SLOTS = DATA_W / PAIR_W;

  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] buf_d;
  logic [FILL_W-1:0] fill_q;
  logic [FILL_W-1:0] fill_d;
  logic              full_q;

  assign full_q = (fill_q == FILL_W'(SLOTS));

  // Each slot either clears, captures the incoming pair when it is the next free slot, or holds.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign buf_d[gi*PAIR_W +: PAIR_W] =
        clear_i                                           ? '0     :
        (push_i && !full_q && (fill_q == FILL_W'(gi)))    ? pair_i :
                                                            buf_q[gi*PAIR_W +: PAIR_W];
  end

  // Fill count follows the slot writes; a push into a full buffer is dropped.
  always_comb begin
    fill_d = fill_q;
    if (clear_i) begin
      fill_d = '0;
    end else if (push_i && !full_q) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // Buffer and fill registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign buf_next_o  = buf_d;
  assign fill_next_o = fill_d;
  assign full_next_o = (fill_d == FILL_W'(SLOTS));

endmodule

// File: rtl/rle_encoder_param.sv
// rle_encoder_param: run-length encoder reading symbols from SRAM port A and
// writing packed {count,symbol} pairs back through the same port.
// Build option RLE_STATS_EN adds run_count (pairs emitted) and max_run
// (longest pair count of the current job).
module rle_encoder_param
  import rle_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  input  logic [31:0]       rle_addr,
  output logic [31:0]       rle_size,
  output logic              done,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [DATA_W-1:0] port_A_data_in,
  input  logic [DATA_W-1:0] port_A_data_out
`ifdef RLE_STATS_EN
  ,
  output logic [31:0]       run_count,
  output logic [CNT_W-1:0]  max_run
`endif
);

  localparam int PW         = pair_width(SYM_W, CNT_W);
  localparam int SPW        = syms_per_word(DATA_W, SYM_W);
  localparam int PPW        = pairs_per_word(DATA_W, PW);
  localparam int STEP       = byte_step(DATA_W);
  localparam int PAIR_BYTES = PW / 8;
  localparam int SEL_W      = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int FILL_W     = $clog2(PPW + 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = '1;

  rle_state_e        state_q;
  logic              done_q;
  logic [31:0]       rle_size_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_in_q;
  logic [ADDR_W-1:0] msg_ptr_q;
  logic [ADDR_W-1:0] out_ptr_q;
  logic [31:0]       rem_q;
  logic [DATA_W-1:0] word_q;
  logic [SEL_W-1:0]  sym_idx_q;
  logic              word_empty_q;
  logic [SYM_W-1:0]  cur_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_valid_q;

  logic [SYM_W-1:0]  scan_sym;
  logic              run_match;
  logic              word_end;
  logic              start_ok;
  logic              pk_clear;
  logic              pk_push;
  logic [PW-1:0]     pk_pair;
  logic [DATA_W-1:0] pk_buf_next;
  logic [FILL_W-1:0] pk_fill_next;
  logic              pk_full_next;
  logic [31:0]       flush_bytes;

  // Upper address bits beyond the SRAM range are intentionally ignored.
  if (ADDR_W < 32) begin : g_addr_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^{message_addr[31:ADDR_W], rle_addr[31:ADDR_W]};
  end

  // Split the captured word into symbols; spare select codes read as zero.
  logic [SYM_W-1:0] word_syms [2**SEL_W];
  for (genvar gi = 0; gi < 2**SEL_W; gi++) begin : g_sym
    if (gi < SPW) begin : g_real
      assign word_syms[gi] = word_q[gi*SYM_W +: SYM_W];
    end else begin : g_pad
      assign word_syms[gi] = '0;
    end
  end

  // Run tracker decisions: extend the current run or close it into a pair.
  always_comb begin
    scan_sym    = word_syms[sym_idx_q];
    run_match   = run_valid_q && (scan_sym == cur_q) && (cnt_q != RUN_LIMIT);
    word_end    = (sym_idx_q == SEL_W'(SPW - 1));
    start_ok    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    pk_clear    = start_ok || (state_q == ST_WR);
    pk_push     = (state_q == ST_SCAN) && run_valid_q && ((rem_q == 32'd0) || !run_match);
    pk_pair     = {cnt_q, cur_q};
    flush_bytes = 32'(pk_fill_next) * 32'(PAIR_BYTES);
  end

  rle_pair_packer #(
    .DATA_W (DATA_W),
    .PAIR_W (PW),
    .FILL_W (FILL_W)
  ) u_packer (
    .clk_i       (clk),
    .reset_i     (reset),
    .clear_i     (pk_clear),
    .push_i      (pk_push),
    .pair_i      (pk_pair),
    .buf_next_o  (pk_buf_next),
    .fill_next_o (pk_fill_next),
    .full_next_o (pk_full_next)
  );

  // Main controller: sequencing, pointers, run tracking and registered SRAM outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      rle_size_q   <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_in_q    <= '0;
      msg_ptr_q    <= '0;
      out_ptr_q    <= '0;
      rem_q        <= '0;
      word_q       <= '0;
      sym_idx_q    <= '0;
      word_empty_q <= 1'b0;
      cur_q        <= '0;
      cnt_q        <= '0;
      run_valid_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            rle_size_q  <= '0;
            run_valid_q <= 1'b0;
            if (message_size == 32'd0) begin
              // Empty message completes immediately without touching the SRAM.
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              done_q    <= 1'b0;
              msg_ptr_q <= message_addr[ADDR_W-1:0];
              addr_q    <= message_addr[ADDR_W-1:0];
              out_ptr_q <= rle_addr[ADDR_W-1:0];
              rem_q     <= message_size;
              state_q   <= ST_RD_REQ;
            end
          end else if (state_q == ST_DONE) begin
            state_q <= ST_IDLE;
          end
        end

        ST_RD_REQ: begin
          msg_ptr_q <= msg_ptr_q + ADDR_W'(STEP);
          state_q   <= ST_RD_WAIT;
        end

        ST_RD_WAIT: begin
          word_q       <= port_A_data_out;
          sym_idx_q    <= '0;
          word_empty_q <= 1'b0;
          state_q      <= ST_SCAN;
        end

        ST_SCAN: begin
          if (rem_q == 32'd0) begin
            // All symbols consumed: the final run has just been pushed, so the
            // buffer holds at least one pair and is always written out here.
            run_valid_q <= 1'b0;
            we_q        <= 1'b1;
            addr_q      <= out_ptr_q;
            data_in_q   <= pk_buf_next;
            out_ptr_q   <= out_ptr_q + ADDR_W'(STEP);
            rle_size_q  <= rle_size_q + flush_bytes;
            state_q     <= pk_full_next ? ST_WR : ST_FLUSH;
          end else begin
            rem_q        <= rem_q - 32'd1;
            sym_idx_q    <= sym_idx_q + SEL_W'(1);
            word_empty_q <= word_end;
            run_valid_q  <= 1'b1;
            if (run_match) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end else begin
              cur_q <= scan_sym;
              cnt_q <= CNT_W'(1);
            end
            if (pk_push && pk_full_next) begin
              we_q       <= 1'b1;
              addr_q     <= out_ptr_q;
              data_in_q  <= pk_buf_next;
              out_ptr_q  <= out_ptr_q + ADDR_W'(STEP);
              rle_size_q <= rle_size_q + 32'(STEP);
              state_q    <= ST_WR;
            end else if (rem_q == 32'd1) begin
              state_q <= ST_SCAN;
            end else if (word_end) begin
              addr_q  <= msg_ptr_q;
              state_q <= ST_RD_REQ;
            end
          end
        end

        ST_WR: begin
          // Buffer clears this cycle; resume wherever the scan left off.
          if (rem_q == 32'd0) begin
            state_q <= run_valid_q ? ST_SCAN : ST_FLUSH;
          end else if (word_empty_q) begin
            addr_q  <= msg_ptr_q;
            state_q <= ST_RD_REQ;
          end else begin
            state_q <= ST_SCAN;
          end
        end

        ST_FLUSH: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RLE_STATS_EN
  logic [31:0]      run_count_q;
  logic [CNT_W-1:0] max_run_q;

  // Job statistics: count every pair pushed and remember the largest count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_count_q <= '0;
      max_run_q   <= '0;
    end else if (start_ok) begin
      run_count_q <= '0;
      max_run_q   <= '0;
    end else if (pk_push) begin
      run_count_q <= run_count_q + 32'd1;
      if (cnt_q > max_run_q) begin
        max_run_q <= cnt_q;
      end
    end
  end

  assign run_count = run_count_q;
  assign max_run   = max_run_q;
`endif

  assign rle_size       = rle_size_q;
  assign done           = done_q;
  assign port_A_clk     = clk;
  assign port_A_addr    = addr_q;
  assign port_A_we      = we_q;
  assign port_A_data_in = data_in_q;

endmodule
